mandelbrot_render_core: RTL and testbench

//  Parametrised Mandelbrot pixel engine, successor to the fixed VGA pattern generator.

---
 rtl/mandelbrot_pkg.sv | 37 +++
 rtl/mandelbrot_render_core_if.sv | 33 +++
 rtl/mandelbrot_iter_step.sv | 31 +++
 rtl/mandelbrot_render_core.sv | 176 +++++++++++++++++
 tb/tb_mandelbrot_render_core.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot pixel engine.
// Build option: MANDEL_BULB_SKIP_EN enables the period-2 bulb early-out (uses bulb_r2).
package mandelbrot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Widest supported word; helpers work at this width and callers cast down.
  localparam int unsigned FX_MAX_W = 64;

  typedef logic signed [FX_MAX_W-1:0]   fx_word_t;
  typedef logic signed [2*FX_MAX_W-1:0] fx_wide_t;

  function automatic fx_wide_t fx_mul(input fx_word_t a, input fx_word_t b);
    return fx_wide_t'(a) * fx_wide_t'(b);
  endfunction

  function automatic fx_wide_t fx_trunc(input fx_wide_t x, input int unsigned frac_bits);
    return x >>> frac_bits;
  endfunction

  // 4.0 in Q(2*frac_bits)
  function automatic fx_wide_t escape_r2(input int unsigned frac_bits);
    return fx_wide_t'(4) << (2 * frac_bits);
  endfunction

  // 1/16 in Q(2*frac_bits)
  function automatic fx_wide_t bulb_r2(input int unsigned frac_bits);
    return fx_wide_t'(1) << (2 * frac_bits - 4);
  endfunction

endpackage

// File: rtl/mandelbrot_render_core_if.sv
// Config/start inputs plus the pixel result stream of the render core.
interface mandelbrot_render_core_if #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 8
);
  localparam int unsigned X_W = $clog2(H_RES);
  localparam int unsigned Y_W = $clog2(V_RES);

  logic                    iStart;
  logic signed [WIDTH-1:0] iCx0;
  logic signed [WIDTH-1:0] iCy0;
  logic signed [WIDTH-1:0] iStep;
  logic [ITER_W-1:0]       iMax_Iter;
  logic                    oPix_Valid;
  logic                    iPix_Ready;
  logic [X_W-1:0]          oPix_X;
  logic [Y_W-1:0]          oPix_Y;
  logic [ITER_W-1:0]       oPix_Iter;
  logic                    oBusy;
  logic                    oFrame_Done;

  modport master (
    output iStart, iCx0, iCy0, iStep, iMax_Iter, iPix_Ready,
    input  oPix_Valid, oPix_X, oPix_Y, oPix_Iter, oBusy, oFrame_Done
  );

  modport slave (
    input  iStart, iCx0, iCy0, iStep, iMax_Iter, iPix_Ready,
    output oPix_Valid, oPix_X, oPix_Y, oPix_Iter, oBusy, oFrame_Done
  );
endinterface

// File: rtl/mandelbrot_iter_step.sv
// Combinational datapath for one z = z^2 + c step plus the |z|^2 > 4 escape test.
module mandelbrot_iter_step
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 28
) (
  input  logic signed [WIDTH-1:0] zr_i,
  input  logic signed [WIDTH-1:0] zi_i,
  input  logic signed [WIDTH-1:0] cr_i,
  input  logic signed [WIDTH-1:0] ci_i,
  output logic signed [WIDTH-1:0] zr_o,
  output logic signed [WIDTH-1:0] zi_o,
  output logic                    escape_o
);
  // One guard bit above the 2*WIDTH products keeps sums and the doubling exact.
  localparam int unsigned PW = 2 * WIDTH + 1;

  logic signed [PW-1:0] zr2, zi2, zrzi2, mag, diff;

  assign zr2   = PW'(fx_mul(fx_word_t'(zr_i), fx_word_t'(zr_i)));
  assign zi2   = PW'(fx_mul(fx_word_t'(zi_i), fx_word_t'(zi_i)));
  assign zrzi2 = PW'(fx_mul(fx_word_t'(zr_i), fx_word_t'(zi_i))) <<< 1;
  assign mag   = zr2 + zi2;
  assign diff  = zr2 - zi2;

  assign escape_o = mag > PW'(escape_r2(FRAC_BITS));
  assign zr_o     = WIDTH'(fx_trunc(fx_wide_t'(diff), FRAC_BITS)) + cr_i;
  assign zi_o     = WIDTH'(fx_trunc(fx_wide_t'(zrzi2), FRAC_BITS)) + ci_i;

endmodule

// File: rtl/mandelbrot_render_core.sv
// Raster-scanning Mandelbrot engine: one iteration per clock, one (x,y,iter) per pixel.
// Build option: MANDEL_BULB_SKIP_EN skips iteration for c inside the period-2 bulb.
module mandelbrot_render_core
  import mandelbrot_pkg::*;
#(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 28,
  parameter int unsigned ITER_W    = 8
) (
  input logic                     iCLK,
  input logic                     iRST,
  mandelbrot_render_core_if.slave bus
);
  localparam int unsigned X_W = $clog2(H_RES);
  localparam int unsigned Y_W = $clog2(V_RES);

  state_e                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
  logic signed [WIDTH-1:0] cx0_q, cx0_d, step_q, step_d;
  logic [ITER_W-1:0]       iter_q, iter_d, max_q, max_d;
  logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic signed [WIDTH-1:0] zr_nx, zi_nx;
  logic                    escape;
  logic                    last_col, last_row;

  mandelbrot_iter_step #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_step (
    .zr_i     (zr_q),
    .zi_i     (zi_q),
    .cr_i     (cr_q),
    .ci_i     (ci_q),
    .zr_o     (zr_nx),
    .zi_o     (zi_nx),
    .escape_o (escape)
  );

`ifdef MANDEL_BULB_SKIP_EN
  localparam logic signed [WIDTH:0] ONE = (WIDTH + 1)'(1) << FRAC_BITS;
  logic signed [WIDTH:0] bulb_re;
  fx_wide_t              bulb_dist;
  logic                  bulb_hit;

  // (cr+1)^2 + ci^2 < 1/16 marks the period-2 bulb centred on -1.
  assign bulb_re   = (WIDTH + 1)'(cr_q) + ONE;
  assign bulb_dist = fx_mul(fx_word_t'(bulb_re), fx_word_t'(bulb_re))
                   + fx_mul(fx_word_t'(ci_q), fx_word_t'(ci_q));
  assign bulb_hit  = bulb_dist < bulb_r2(FRAC_BITS);
`endif

  assign last_col = x_q == X_W'(H_RES - 1);
  assign last_row = y_q == Y_W'(V_RES - 1);

  // Next-state, datapath updates and registered output values.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cx0_d   = cx0_q;
    step_d  = step_q;
    iter_d  = iter_q;
    max_d   = max_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          cx0_d   = bus.iCx0;
          step_d  = bus.iStep;
          max_d   = (bus.iMax_Iter == '0) ? ITER_W'(1) : bus.iMax_Iter;
          cr_d    = bus.iCx0;
          ci_d    = bus.iCy0;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        zr_d    = '0;
        zi_d    = '0;
        iter_d  = '0;
        state_d = ST_ITER;
`ifdef MANDEL_BULB_SKIP_EN
        if (bulb_hit) begin
          iter_d  = max_q;
          state_d = ST_EMIT;
        end
`endif
      end
      ST_ITER: begin
        if (escape || iter_q == max_q) begin
          state_d = ST_EMIT;
        end else begin
          zr_d   = zr_nx;
          zi_d   = zi_nx;
          iter_d = iter_q + ITER_W'(1);
        end
      end
      ST_EMIT: begin
        if (bus.iPix_Ready) begin
          if (last_col && last_row) begin
            state_d = ST_DONE;
          end else if (last_col) begin
            x_d     = '0;
            cr_d    = cx0_q;
            y_d     = y_q + Y_W'(1);
            ci_d    = ci_q + step_q;
            state_d = ST_LOAD;
          end else begin
            x_d     = x_q + X_W'(1);
            cr_d    = cr_q + step_q;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = state_d == ST_EMIT;
    busy_d  = state_d inside {ST_LOAD, ST_ITER, ST_EMIT};
    done_d  = state_d == ST_DONE;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      cx0_q   <= '0;
      step_q  <= '0;
      iter_q  <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cx0_q   <= cx0_d;
      step_q  <= step_d;
      iter_q  <= iter_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.oPix_Valid  = valid_q;
  assign bus.oPix_X      = x_q;
  assign bus.oPix_Y      = y_q;
  assign bus.oPix_Iter   = iter_q;
  assign bus.oBusy       = busy_q;
  assign bus.oFrame_Done = done_q;

endmodule

// File: tb/tb_mandelbrot_render_core.sv
// Randomised scoreboard bench for mandelbrot_render_core on a 4x2 grid.
module tb_mandelbrot_render_core;

  localparam int H = 4;
  localparam int V = 2;
  localparam int Q = 28;
  localparam int ONE = 1 << Q;

  typedef struct {
    int x;
    int y;
    int it;
  } exp_t;

  logic iCLK;
  logic iRST;

  mandelbrot_render_core_if #(.H_RES(H), .V_RES(V), .WIDTH(32), .ITER_W(8)) bus ();

  mandelbrot_render_core #(
    .H_RES(H), .V_RES(V), .WIDTH(32), .FRAC_BITS(Q), .ITER_W(8)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   done_cnt = 0;
  int   acc_cnt  = 0;
  int   acc_x    = -1;
  int   acc_y    = -1;
  int   rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
  bit   spacing_en = 0;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic check(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Escape-time reference: iterate straight from the definition with wide integers.
  function automatic int ref_iter(input int cr, input int ci, input int mx);
    int zr = 0;
    int zi = 0;
    longint rr, ii, ri;
    for (int n = 0; n <= mx; n++) begin
      rr = longint'(zr) * longint'(zr);
      ii = longint'(zi) * longint'(zi);
      ri = longint'(zr) * longint'(zi);
      if (rr + ii > (longint'(4) <<< (2 * Q)) || n == mx) return n;
      zr = int'((rr - ii) >>> Q) + cr;
      zi = int'((2 * ri) >>> Q) + ci;
    end
    return mx;
  endfunction

  // Ready driver
  initial begin
    bus.iPix_Ready = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      case (rdy_mode)
        0:       bus.iPix_Ready = 1'b1;
        1:       bus.iPix_Ready = 1'($urandom_range(0, 1));
        default: bus.iPix_Ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit     hold_pend = 0;
    longint held = 0;
    longint cur;
    longint prev_t = -1;
    exp_t   e;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        exp_q.delete();
        hold_pend = 0;
      end else begin
        cur = {bus.oPix_Valid, bus.oPix_X, bus.oPix_Y, bus.oPix_Iter};
        if (bus.oFrame_Done) done_cnt++;
        if (hold_pend) check("stall_hold", cur, held);
        hold_pend = bus.oPix_Valid && !bus.iPix_Ready;
        held = cur;
        if (!spacing_en) prev_t = -1;
        if (bus.oPix_Valid && bus.iPix_Ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pix_x", bus.oPix_X, e.x);
            check("pix_y", bus.oPix_Y, e.y);
            check("pix_iter", bus.oPix_Iter, e.it);
          end
          acc_x = int'(bus.oPix_X);
          acc_y = int'(bus.oPix_Y);
          acc_cnt++;
          if (spacing_en) begin
            if (prev_t >= 0) check("pixel_spacing", longint'($time) - prev_t, 40);
            prev_t = longint'($time);
          end
        end
      end
    end
  end

  int done_base;

  task automatic start_frame(input int cx0, input int cy0, input int step, input int mx);
    exp_t e;
    int   mx_eff;
    mx_eff = (mx == 0) ? 1 : mx;
    @(posedge iCLK);
    #1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        e.x  = x;
        e.y  = y;
        e.it = ref_iter(cx0 + x * step, cy0 + y * step, mx_eff);
        exp_q.push_back(e);
      end
    done_base     = done_cnt;
    bus.iCx0      = cx0;
    bus.iCy0      = cy0;
    bus.iStep     = step;
    bus.iMax_Iter = 8'(mx);
    bus.iStart    = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == done_base && n < 20000) begin
      @(negedge iCLK);
      n++;
    end
    check({nm, "_done_seen"}, done_cnt > done_base, 1);
    repeat (3) @(negedge iCLK);
    check({nm, "_done_once"}, done_cnt - done_base, 1);
    check({nm, "_all_pixels"}, exp_q.size(), 0);
    check({nm, "_idle_busy"}, bus.oBusy, 0);
  endtask

  task automatic wait_accept(input int x, input int y);
    int n = 0;
    while (!(acc_x == x && acc_y == y) && n < 5000) begin
      @(negedge iCLK);
      n++;
    end
    check("accept_wait", (acc_x == x && acc_y == y), 1);
  endtask

  initial begin
    int n;
    iRST          = 1'b1;
    bus.iStart    = 1'b0;
    bus.iCx0      = '0;
    bus.iCy0      = '0;
    bus.iStep     = '0;
    bus.iMax_Iter = '0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    check("rst_valid", bus.oPix_Valid, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_done", bus.oFrame_Done, 0);
    check("rst_x", bus.oPix_X, 0);
    check("rst_y", bus.oPix_Y, 0);
    check("rst_iter", bus.oPix_Iter, 0);

    // Directed raster frame c = -2 + (x + y i)/2
    start_frame(-2 * ONE, 0, ONE / 2, 16);
    @(negedge iCLK);
    check("busy_in_frame", bus.oBusy, 1);
    wait_done("raster");

    // Immediate escape: every pixel one update, four cycles per pixel
    spacing_en = 1;
    start_frame(3 * ONE, 0, 0, 16);
    wait_done("c3");
    spacing_en = 0;

    // Backpressure on pixel (1,0)
    start_frame(-ONE, ONE / 4, ONE / 8, 20);
    wait_accept(0, 0);
    rdy_mode = 2;
    n = 0;
    while (!(bus.oPix_Valid && bus.oPix_X == 2'd1) && n < 2000) begin
      @(negedge iCLK);
      n++;
    end
    check("stall_reached", bus.oPix_Valid, 1);
    repeat (5) @(posedge iCLK);
    rdy_mode = 0;
    wait_done("stall");

    // iStart mid-frame with new config must be ignored
    start_frame(-ONE / 2, ONE / 8, ONE / 4, 30);
    repeat (15) @(posedge iCLK);
    #1;
    bus.iCx0   = ONE;
    bus.iStep  = ONE;
    bus.iStart = 1'b1;
    @(posedge iCLK);
    #1 bus.iStart = 1'b0;
    wait_done("restart_ignored");

    // Reset while pixel (2,1) is iterating drops the frame
    start_frame(-ONE / 2, 0, ONE / 16, 16);
    wait_accept(1, 1);
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    check("midrst_valid", bus.oPix_Valid, 0);
    check("midrst_busy", bus.oBusy, 0);
    check("midrst_x", bus.oPix_X, 0);
    check("midrst_y", bus.oPix_Y, 0);
    check("midrst_queue", exp_q.size(), 0);
    start_frame(-2 * ONE, 0, ONE / 2, 16);
    wait_done("after_reset");

    // iMax_Iter = 0 behaves as 1
    start_frame(-ONE, 0, ONE / 4, 0);
    wait_done("max0");

    // Randomised frames with random ready
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      start_frame(-2 * ONE + int'($urandom_range(0, 5 * (ONE / 2))),
                  -(ONE + ONE / 4) + int'($urandom_range(0, 5 * (ONE / 2))),
                  int'($urandom_range(0, ONE / 4)),
                  (f == 7) ? 255 : int'($urandom_range(0, 60)));
      wait_done("random");
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
